// File: rtl/celebration_ctrl.sv
// Win celebration sequencer: waits a few OLED frames after a win, then blinks the
// celebration glyphs in SHOW/BLANK phases for a fixed number of frames.
module celebration_ctrl #(
   parameter int unsigned ARM_FRAMES   = 2,
   parameter int unsigned HOLD_FRAMES  = 120,
   parameter int unsigned BLINK_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       win_pulse,
   input  logic       frame_begin,
   input  logic       skip,
   output logic       celebrationState,
   output logic       busy,
   output logic       done_pulse,
   output logic [7:0] frames_left,
   output logic [3:0] win_count
);

   localparam int unsigned FL_W    = 8;
   localparam int unsigned WC_W    = 4;
   localparam int unsigned ARM_W   = (ARM_FRAMES < 1) ? 1 : $clog2(ARM_FRAMES + 1);
   localparam int unsigned PHASE_W = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);

   localparam logic [FL_W-1:0]    HOLD_INIT  = FL_W'(HOLD_FRAMES);
   localparam logic [WC_W-1:0]    WC_MAX     = '1;
   localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_FRAMES);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_FRAMES);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      SHOW  = 3'd2,
      BLANK = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
   logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [FL_W-1:0]    frames_left_q, frames_left_d;
   logic [WC_W-1:0]    win_count_q, win_count_d;
   logic               celebration_q, celebration_d;
   logic               busy_q, busy_d;
   logic               done_pulse_q, done_pulse_d;

   logic [ARM_W-1:0]   arm_inc;
   logic [PHASE_W-1:0] phase_inc;
   logic [FL_W-1:0]    fl_dec;

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         arm_cnt_q     <= '0;
         phase_cnt_q   <= '0;
         frames_left_q <= '0;
         win_count_q   <= '0;
         celebration_q <= 1'b0;
         busy_q        <= 1'b0;
         done_pulse_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_cnt_q     <= arm_cnt_d;
         phase_cnt_q   <= phase_cnt_d;
         frames_left_q <= frames_left_d;
         win_count_q   <= win_count_d;
         celebration_q <= celebration_d;
         busy_q        <= busy_d;
         done_pulse_q  <= done_pulse_d;
      end
   end

   assign arm_inc   = arm_cnt_q + ARM_W'(1);
   assign phase_inc = phase_cnt_q + PHASE_W'(1);
   // Saturate at zero so frames_left can never wrap.
   assign fl_dec    = (frames_left_q == '0) ? '0 : frames_left_q - FL_W'(1);

   // Next state and counters; frames_left reaching zero outranks the blink toggle
   always_comb begin
      state_d       = state_q;
      arm_cnt_d     = arm_cnt_q;
      phase_cnt_d   = phase_cnt_q;
      frames_left_d = frames_left_q;
      win_count_d   = win_count_q;

      case (state_q)
         IDLE: begin
            if (win_pulse) begin
               state_d       = ARM;
               frames_left_d = HOLD_INIT;
               phase_cnt_d   = '0;
               arm_cnt_d     = '0;
               if (win_count_q != WC_MAX) begin
                  win_count_d = win_count_q + WC_W'(1);
               end
            end
         end

         ARM: begin
            if (skip) begin
               state_d       = DONE;
               frames_left_d = '0;
            end else if (ARM_FRAMES == 0) begin
               state_d     = SHOW;
               phase_cnt_d = '0;
            end else if (frame_begin) begin
               arm_cnt_d = arm_inc;
               if (arm_inc == ARM_LAST) begin
                  state_d     = SHOW;
                  phase_cnt_d = '0;
               end
            end
         end

         SHOW, BLANK: begin
            if (skip) begin
               state_d       = DONE;
               frames_left_d = '0;
            end else if (frame_begin) begin
               frames_left_d = fl_dec;
               if (fl_dec == '0) begin
                  state_d     = DONE;
                  phase_cnt_d = '0;
               end else if (phase_inc == PHASE_LAST) begin
                  phase_cnt_d = '0;
                  state_d     = (state_q == SHOW) ? BLANK : SHOW;
               end else begin
                  phase_cnt_d = phase_inc;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with state_q
   always_comb begin
      celebration_d = 1'b0;
      busy_d        = 1'b0;
      done_pulse_d  = 1'b0;
      case (state_d)
         ARM:     busy_d = 1'b1;
         SHOW: begin
            busy_d        = 1'b1;
            celebration_d = 1'b1;
         end
         BLANK:   busy_d = 1'b1;
         DONE: begin
            busy_d       = 1'b1;
            done_pulse_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign celebrationState = celebration_q;
   assign busy             = busy_q;
   assign done_pulse       = done_pulse_q;
   assign frames_left      = frames_left_q;
   assign win_count        = win_count_q;

endmodule
